wb_stage: RTL

Write-back pipeline stage of the 32-bit processor. It holds the W pipeline register loaded from the memory stage and drives the register file's two write ports (dstE/valE, dstM/valM). It suppresses writes for bubbles, faulting instructions and same-register conflicts, and latches the processor's terminal status. It optionally counts retired instructions.

---
 rtl/wb_stage.sv | 123 ++++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline stage.
// Holds the W pipeline register, drives the two register-file write ports
// with bubble/fault/conflict suppression, and latches the sticky halt.
// Optional feature macro: WB_RETIRE_CNT_EN builds the retired-instruction
// counter; when undefined, retired is tied to zero.
module wb_stage #(
  parameter logic [3:0] RNONE     = 4'hF,
  parameter logic [2:0] STAT_AOK  = 3'd1,
  parameter logic [3:0] NOP_ICODE = 4'h1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [2:0]  m_stat,
  input  logic [3:0]  m_icode,
  input  logic [31:0] m_valE,
  input  logic [31:0] m_valM,
  input  logic [3:0]  m_dstE,
  input  logic [3:0]  m_dstM,
  input  logic        w_stall,
  input  logic        w_bubble,
  output logic [3:0]  dstE,
  output logic [31:0] valE,
  output logic [3:0]  dstM,
  output logic [31:0] valM,
  output logic [3:0]  w_icode,
  output logic [2:0]  w_stat,
  output logic        halted,
  output logic [31:0] retired
);

  logic        w_valid;
  logic [2:0]  w_stat_q;
  logic [3:0]  w_icode_q;
  logic [31:0] w_vale_q;
  logic [31:0] w_valm_q;
  logic [3:0]  w_dste_q;
  logic [3:0]  w_dstm_q;
  logic        halted_q;

  logic        load_insn;
  logic        load_bubble;

  // Load decision: halt freezes W, stall beats bubble, invalid input is a bubble
  always_comb begin
    load_insn   = !halted_q && !w_stall && !w_bubble && m_valid;
    load_bubble = !halted_q && !w_stall && (w_bubble || !m_valid);
  end

  // W pipeline register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      w_valid   <= 1'b0;
      w_stat_q  <= STAT_AOK;
      w_icode_q <= NOP_ICODE;
      w_vale_q  <= '0;
      w_valm_q  <= '0;
      w_dste_q  <= RNONE;
      w_dstm_q  <= RNONE;
    end else if (load_bubble) begin
      w_valid   <= 1'b0;
      w_stat_q  <= STAT_AOK;
      w_icode_q <= NOP_ICODE;
      w_vale_q  <= '0;
      w_valm_q  <= '0;
      w_dste_q  <= RNONE;
      w_dstm_q  <= RNONE;
    end else if (load_insn) begin
      w_valid   <= 1'b1;
      w_stat_q  <= m_stat;
      w_icode_q <= m_icode;
      w_vale_q  <= m_valE;
      w_valm_q  <= m_valM;
      w_dste_q  <= m_dstE;
      w_dstm_q  <= m_dstM;
    end
  end

  // Sticky halt: set when a faulting instruction enters W, cleared by reset only
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      halted_q <= 1'b0;
    end else if (load_insn && (m_stat != STAT_AOK)) begin
      halted_q <= 1'b1;
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retired_cnt;

  // Retired-instruction counter, wraps naturally at 32 bits
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retired_cnt <= '0;
    end else if (load_insn && (m_stat == STAT_AOK)) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end

  assign retired = retired_cnt;
`else
  assign retired = '0;
`endif

  // Write-port suppression from W state only; M port wins a same-register conflict
  always_comb begin
    dstE = w_dste_q;
    dstM = w_dstm_q;
    if (!w_valid || (w_stat_q != STAT_AOK)) begin
      dstE = RNONE;
      dstM = RNONE;
    end else if ((w_dste_q == w_dstm_q) && (w_dste_q != RNONE)) begin
      dstE = RNONE;
    end
  end

  assign valE    = w_vale_q;
  assign valM    = w_valm_q;
  assign w_icode = w_icode_q;
  assign w_stat  = w_stat_q;
  assign halted  = halted_q;

endmodule
